// File: rtl/fault_sim_pkg.sv
// Shared types and default constants for the fault-simulation response checker.
package fault_sim_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [15:0] SIG_SEED_ONES = 16'hFFFF;

endpackage

// File: rtl/fault_response_checker_misr_reg.sv
// Multiple-input signature register: shift left, fold MSB through POLY, XOR in response bits.
module misr_reg
  import fault_sim_pkg::*;
#(
  parameter int                 WIDTH = 1,
  parameter int                 SIG_W = 16,
  parameter logic [SIG_W-1:0]   POLY  = SIG_W'(CRC16_POLY),
  parameter logic [SIG_W-1:0]   SEED  = SIG_W'(SIG_SEED_ONES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] r_sig;

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [WIDTH-1:0] d);
    logic [SIG_W-1:0] fb;
    fb = s[SIG_W-1] ? POLY : {SIG_W{1'b0}};
    return {s[SIG_W-2:0], 1'b0} ^ fb ^ SIG_W'(d);
  endfunction

  // Load wins over shift so a restart never folds a stray beat into the seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= SEED;
    end else if (load) begin
      r_sig <= SEED;
    end else if (shift_en) begin
      r_sig <= misr_step(r_sig, din);
    end else begin
      r_sig <= r_sig;
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/fault_response_checker.sv
// Collects response beats into a MISR over a programmed pattern count, then
// compares the signature against a golden value and holds pass/fail.
module fault_response_checker
  import fault_sim_pkg::*;
#(
  parameter int               WIDTH = 1,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(CRC16_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(SIG_SEED_ONES),
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_num_pats,
  input  logic [SIG_W-1:0] i_exp_sig,
  input  logic             i_resp_valid,
  input  logic [WIDTH-1:0] i_resp_data,
  output logic             o_resp_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [SIG_W-1:0] o_signature,
  output logic [CNT_W-1:0] o_pat_count
);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_num_pats;
  logic [SIG_W-1:0] r_exp_sig;
  logic [CNT_W-1:0] r_pat_count;
  logic             r_pass;
  logic             w_load;
  logic             w_shift;
  logic [SIG_W-1:0] w_sig;

  misr_reg #(
    .WIDTH (WIDTH),
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .shift_en (w_shift),
    .din      (i_resp_data),
    .sig      (w_sig)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and MISR control; resp_ready is implied by COLLECT alone.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (i_start) begin
          w_load       = 1'b1;
          w_next_state = (i_num_pats == {CNT_W{1'b0}}) ? COMPARE : COLLECT;
        end else begin
          w_next_state = r_state;
        end
      end
      COLLECT: begin
        if (i_resp_valid) begin
          w_shift = 1'b1;
          if ((r_pat_count + CNT_W'(1)) == r_num_pats) begin
            w_next_state = COMPARE;
          end else begin
            w_next_state = COLLECT;
          end
        end else begin
          w_next_state = COLLECT;
        end
      end
      COMPARE: w_next_state = DONE;
      default: w_next_state = IDLE;
    endcase
  end

  // Session bookkeeping: latched targets, beat counter and verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num_pats  <= {CNT_W{1'b0}};
      r_exp_sig   <= {SIG_W{1'b0}};
      r_pat_count <= {CNT_W{1'b0}};
      r_pass      <= 1'b0;
    end else if (w_load) begin
      r_num_pats  <= i_num_pats;
      r_exp_sig   <= i_exp_sig;
      r_pat_count <= {CNT_W{1'b0}};
      r_pass      <= 1'b0;
    end else if (w_shift) begin
      r_pat_count <= r_pat_count + CNT_W'(1);
    end else if (r_state == COMPARE) begin
      r_pass <= (w_sig == r_exp_sig);
    end else begin
      r_pat_count <= r_pat_count;
    end
  end

  assign o_resp_ready = (r_state == COLLECT);
  assign o_busy       = (r_state == COLLECT) || (r_state == COMPARE);
  assign o_done       = (r_state == DONE);
  assign o_pass       = (r_state == DONE) && r_pass;
  assign o_signature  = w_sig;
  assign o_pat_count  = r_pat_count;

endmodule

// File: tb/tb_fault_response_checker.sv
// Randomized and directed bench for fault_response_checker with a 4-bit MISR.
module tb_fault_response_checker;

  localparam int SW = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_pats = '0;
  logic [SW-1:0] exp_sig = '0;
  logic          resp_valid = 1'b0;
  logic [0:0]    resp_data = '0;
  logic          resp_ready, busy, done, pass;
  logic [SW-1:0] signature;
  logic [CW-1:0] pat_count;

  int errors = 0;
  int checks = 0;
  int ref_sig;
  int ref_cnt;
  bit tab[$];
  bit vmask[$];

  fault_response_checker #(
    .WIDTH (1), .SIG_W (SW), .POLY (4'h3), .SEED (4'h0), .CNT_W (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start),
    .i_num_pats   (num_pats),
    .i_exp_sig    (exp_sig),
    .i_resp_valid (resp_valid),
    .i_resp_data  (resp_data),
    .o_resp_ready (resp_ready),
    .o_busy       (busy),
    .o_done       (done),
    .o_pass       (pass),
    .o_signature  (signature),
    .o_pat_count  (pat_count)
  );

  always #5 clk = ~clk;

  // Signature rule: multiply by x modulo x^4 + x + 1, then add the response bit.
  function automatic int ref_step(input int s, input bit d);
    int v;
    v = (s * 2) % 16;
    if (s >= 8) v = v ^ 3;
    return v ^ int'(d);
  endfunction

  function automatic int ref_of_tab();
    int s = 0;
    foreach (tab[i]) s = ref_step(s, tab[i]);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic do_start(input int n, input int e);
    start = 1'b1;
    num_pats = CW'(n);
    exp_sig = SW'(e);
    tick();
    start = 1'b0;
    num_pats = CW'($urandom);
    exp_sig = SW'($urandom);
    ref_sig = 0;
    ref_cnt = 0;
  endtask

  // Feeds tab[] as beats; bubbles follow vmask when given, else random.
  task automatic send_beats(input int bubble_pct, input bit poke_start);
    int cyc = 0;
    bit v;
    while (ref_cnt < tab.size() && cyc < 1000) begin
      v = (vmask.size() > cyc) ? vmask[cyc] : ($urandom_range(99) >= bubble_pct);
      cyc++;
      chk("ready_in_collect", int'(resp_ready), 1);
      if (!v) begin
        resp_valid = 1'b0;
        resp_data = 1'($urandom);
        if (poke_start) begin
          start = 1'b1;
          num_pats = CW'(1);
        end
        tick();
        start = 1'b0;
        chk("bubble_hold_sig", int'(signature), ref_sig);
        chk("bubble_hold_cnt", int'(pat_count), ref_cnt);
      end else begin
        resp_valid = 1'b1;
        resp_data = tab[ref_cnt];
        tick();
        ref_sig = ref_step(ref_sig, tab[ref_cnt]);
        ref_cnt++;
        chk("beat_sig", int'(signature), ref_sig);
        chk("beat_cnt", int'(pat_count), ref_cnt);
      end
    end
    resp_valid = 1'b0;
    if (ref_cnt < tab.size()) begin
      errors++;
      checks++;
      $display("FAIL beat_timeout: accepted %0d expected %0d", ref_cnt, tab.size());
    end
  endtask

  task automatic finish_check(input bit exp_pass);
    chk("compare_busy", int'(busy), 1);
    chk("compare_ready", int'(resp_ready), 0);
    chk("compare_done", int'(done), 0);
    chk("compare_pass", int'(pass), 0);
    tick();
    chk("done_flag", int'(done), 1);
    chk("done_busy", int'(busy), 0);
    chk("done_pass", int'(pass), int'(exp_pass));
    chk("done_sig", int'(signature), ref_sig);
    chk("done_cnt", int'(pat_count), ref_cnt);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    resp_valid = 1'b1;
    #12;
    chk("rst_sig", int'(signature), 0);
    chk("rst_cnt", int'(pat_count), 0);
    chk("rst_ready", int'(resp_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_ignore_ready", int'(resp_ready), 0);
    chk("idle_ignore_cnt", int'(pat_count), 0);
    resp_valid = 1'b0;
  endtask

  task automatic test_directed();
    tab = '{1'b1, 1'b0, 1'b1, 1'b1};
    vmask.delete();
    do_start(4, 4'hB);
    send_beats(0, 1'b0);
    chk("dir_sig_B", int'(signature), 11);
    finish_check(1'b1);
    do_start(4, 4'hA);
    send_beats(0, 1'b0);
    finish_check(1'b0);
    chk("dir_fail_sig", int'(signature), 11);
    tab = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    do_start(5, 4'h5);
    send_beats(0, 1'b0);
    chk("dir_sig_5", int'(signature), 5);
    finish_check(1'b1);
  endtask

  task automatic test_zero_pats();
    tab.delete();
    do_start(0, 4'h0);
    ref_sig = 0;
    resp_valid = 1'b1;
    finish_check(1'b1);
    chk("zero_ready", int'(resp_ready), 0);
    resp_valid = 1'b0;
  endtask

  task automatic test_bubbles();
    tab = '{1'b1, 1'b0, 1'b1, 1'b1};
    vmask = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    do_start(4, 4'hB);
    send_beats(0, 1'b1);
    chk("bubble_sig_B", int'(signature), 11);
    finish_check(1'b1);
    vmask.delete();
    // Restart from DONE with a beat present: the start must win.
    start = 1'b1;
    num_pats = CW'(4);
    exp_sig = SW'(4'hB);
    resp_valid = 1'b1;
    resp_data = 1'b1;
    tick();
    start = 1'b0;
    resp_valid = 1'b0;
    chk("start_wins_cnt", int'(pat_count), 0);
    chk("start_wins_sig", int'(signature), 0);
    chk("start_wins_done", int'(done), 0);
    ref_sig = 0;
    ref_cnt = 0;
    send_beats(0, 1'b0);
    finish_check(1'b1);
  endtask

  task automatic test_reset_abort();
    tab = '{1'b1, 1'b0};
    do_start(4, 4'hB);
    send_beats(0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_sig", int'(signature), 0);
    chk("abort_cnt", int'(pat_count), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(resp_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tab = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_start(4, 4'hB);
    send_beats(0, 1'b0);
    chk("after_abort_sig", int'(signature), 11);
    finish_check(1'b1);
  endtask

  task automatic test_random();
    int n, golden, e;
    bit good;
    for (int s = 0; s < 8; s++) begin
      n = $urandom_range(12, 1);
      tab.delete();
      for (int i = 0; i < n; i++) tab.push_back(bit'($urandom_range(1)));
      golden = ref_of_tab();
      good = bit'($urandom_range(1));
      e = good ? golden : (golden ^ $urandom_range(15, 1));
      do_start(n, e);
      send_beats(30, 1'b1);
      finish_check(good);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_pats();
    test_bubbles();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fault_response_checker.md
Name: fault_response_checker

Overview:
- Response-side counterpart of the pattern generator used in the fault-simulation benches.
- Accepts DUT output responses one beat per applied pattern and compacts them in a MISR (multiple-input signature register).
- After a programmed number of patterns, compares the signature against a golden value and reports pass/fail.
- Sits between the gate-under-test output (pattout) and the bench/report logic; synthesizable, so it can also serve as on-chip BIST.

Parameters:
- WIDTH, 1, response bits per pattern; must be >= 1 and <= SIG_W.
- SIG_W, 16, signature width; must be >= 2.
- POLY, 16'h1021, MISR feedback polynomial; bit i set means tap x^i, and x^SIG_W is implicit.
- SEED, 16'hFFFF, signature value loaded on start.
- CNT_W, 16, width of the pattern counter.

Ports:
- clk  input  1  clock; all state is updated on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a session; honoured only in IDLE or DONE.
- num_pats  input  CNT_W  pattern count for the session; sampled on start.
- exp_sig  input  SIG_W  golden signature; sampled on start.
- resp_valid  input  1  a response beat is present.
- resp_data  input  WIDTH  response bits.
- resp_ready  output  1  checker can accept a beat.
- busy  output  1  high in COLLECT or COMPARE.
- done  output  1  high in DONE, held until the next accepted start.
- pass  output  1  signature matched; valid while done=1, otherwise 0.
- signature  output  SIG_W  current MISR value.
- pat_count  output  CNT_W  number of beats accepted in the current session.

Behaviour:
- Reset (async assert, synchronous deassert sampled at clk):
  - state=IDLE.
  - signature=SEED, pat_count=0.
  - resp_ready=0, busy=0, done=0, pass=0.
  - Latched num_pats and exp_sig are cleared to 0.
  - Reset asserted mid-session aborts the session immediately; the partial signature is discarded.
- States: IDLE, COLLECT, COMPARE, DONE.
- IDLE or DONE, with start=1:
  - Latch num_pats and exp_sig; signature<=SEED; pat_count<=0; done<=0; pass<=0.
  - Next state is COLLECT, or COMPARE directly if num_pats==0.
- COLLECT:
  - resp_ready=1, combinationally from state only.
  - A beat transfers when resp_valid && resp_ready.
  - On a transfer: signature <= {signature[SIG_W-2:0],1'b0} ^ (signature[SIG_W-1] ? POLY : 0) ^ zero-extended resp_data; pat_count increments.
  - The transfer that brings pat_count to num_pats moves to COMPARE in the same edge.
  - A cycle with resp_valid=0 leaves all state unchanged.
- COMPARE: one cycle; resp_ready=0; pass <= (signature==exp_sig); next state DONE.
- DONE: done=1; signature and pat_count hold.
- Latency: last beat accepted at edge N; COMPARE during cycle N..N+1; done=1 and pass valid after edge N+1.
- Conditions that are ignored:
  - start while busy.
  - resp_valid outside COLLECT; such beats are never accepted and resp_ready stays 0.
- pat_count never wraps within a session, because the session ends at num_pats. num_pats = 2^CNT_W-1 is legal.
- start and resp_valid together in DONE: start wins; the beat is not accepted that cycle.

Decomposition:
- Shared package fault_sim_pkg:
  - state enum {IDLE, COLLECT, COMPARE, DONE}.
  - Default polynomial/seed constants (CRC16_POLY=16'h1021, SIG_SEED_ONES).
- One natural sub-module: misr_reg.
  - Parameters: WIDTH, SIG_W, POLY, SEED.
  - Inputs: clk, rst_n, load, shift_en, din.
  - Output: sig.
  - The top level owns the FSM and counter.

Test Plan:
- Override SIG_W=4, POLY=4'h3, SEED=0, WIDTH=1. Set num_pats=4, exp_sig=4'hB, and send data 1,0,1,1 with resp_valid held high → signature steps 1,2,5,B; pat_count=4; done=1 with pass=1 two edges after the last beat.
- Same config and data, exp_sig=4'hA → done=1, pass=0, signature=4'hB.
- Same config, num_pats=5, data 1,0,1,1,0 → the fifth beat sees MSB=1, so signature=4'h5 (0110^0011); pass=1 iff exp_sig=4'h5.
- num_pats=0 with exp_sig=SEED → no beats accepted; resp_ready never high; done=1, pass=1 two edges after start.
- Bubbles: resp_valid toggling 1,0,0,1,1,0,1 with data 1,x,x,0,1,x,1 → signature is identical to the back-to-back case (4'hB); x beats are ignored.
- Assert rst_n low in the middle of COLLECT after 2 beats → outputs return to reset values asynchronously. A following start with 4 beats gives 4'hB with no residue from the aborted session.
